// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-add unsigned multiplier with Hi/Lo registers and pipeline stall control.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             hilo_sel,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hilo_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     sum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  // The sum's top bit is the carry; it becomes P's new MSB after the shift.
  always_comb begin
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        p_d     = {{WIDTH{1'b0}}, op_b};
        m_d     = op_a;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (abort) state_d = IDLE;
      else begin
        p_d     = {sum, p_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH-1)) ? DONE : RUN;
      end
      DONE: begin
        state_d = IDLE;
        hi_d    = abort ? hi_q : p_q[2*WIDTH-1:WIDTH];
        lo_d    = abort ? lo_q : p_q[WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign stall     = busy & (start | hilo_rd);
  assign hilo_data = hilo_sel ? lo_q : hi_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule
